// File: rtl/output_streamer_pkg.sv
// Shared definitions for the output streamer and the output RAM it reads:
// FSM state encoding and default RAM geometry.
package output_streamer_pkg;

  // Streamer FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StSend  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Default output-RAM geometry, shared with the RAM instance.
  localparam int unsigned DefRamWidth    = 32;
  localparam int unsigned DefRamAddrBits = 2;

endpackage

// File: rtl/output_streamer.sv
// Output streamer: reads NUM_OUTPUTS words from an asynchronous-read output
// RAM and sends them as one AXI-Stream frame (tlast on the final word),
// pulsing done once the last word is accepted.
// Optional build macro OUTPUT_STREAMER_BYTESWAP_EN reverses the byte order of
// each loaded word (RAM_WIDTH must then be a multiple of 8).
module output_streamer
  import output_streamer_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = DefRamWidth,
  parameter int unsigned RAM_ADDR_BITS = DefRamAddrBits,
  parameter int unsigned NUM_OUTPUTS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [RAM_ADDR_BITS-1:0]      read_addr,
  input  logic signed [RAM_WIDTH-1:0]   RAM_out,
  output logic [RAM_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          done
);

  localparam logic [RAM_ADDR_BITS-1:0] LastIdx = RAM_ADDR_BITS'(NUM_OUTPUTS - 1);

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
  logic [RAM_WIDTH-1:0]     tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  logic [RAM_WIDTH-1:0]     load_data;
  logic                     handshake;

  assign handshake = tvalid_q && m_axis_tready;

  // Word as it will be loaded into the output register.
  always_comb begin
    load_data = '0;
`ifdef OUTPUT_STREAMER_BYTESWAP_EN
    for (int unsigned b = 0; b < RAM_WIDTH / 8; b++) begin
      load_data[8*b +: 8] = RAM_out[RAM_WIDTH-8-8*b +: 8];
    end
`else
    load_data = RAM_out;
`endif
  end

  // Next-state, index, output-register and read-address decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    read_addr = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        read_addr = idx_q;
        tdata_d   = load_data;
        tvalid_d  = 1'b1;
        state_d   = StSend;
      end
      StSend: begin
        // Prefetch the next word so a handshake can reload in the same edge.
        read_addr = idx_q + 1'b1;
        if (handshake) begin
          if (idx_q == LastIdx) begin
            tvalid_d = 1'b0;
            state_d  = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            tdata_d = load_data;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q && (idx_q == LastIdx);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_output_streamer.sv
// Self-checking bench for output_streamer: table-driven frames with tready
// patterns, a scoreboard queue of expected words, and hand-written sequences
// for reset mid-frame, start while busy and a single-word frame.
module tb_output_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [1:0]  read_addr, read_addr2;
  logic signed [31:0] ram_out, ram_out2;
  logic [31:0] tdata, tdata2;
  logic        tvalid, tvalid2, tready, tready2, tlast, tlast2;
  logic        busy, busy2, done, done2;

  logic [31:0] ram [4];

  always #5 clk = ~clk;

  assign ram_out  = ram[read_addr];
  assign ram_out2 = (read_addr2 == 2'd0) ? 32'h1234_5678 : 32'hDEAD_BEEF;

  output_streamer #(.RAM_WIDTH(32), .RAM_ADDR_BITS(2), .NUM_OUTPUTS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .read_addr(read_addr), .RAM_out(ram_out),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .busy(busy), .done(done)
  );

  output_streamer #(.RAM_WIDTH(32), .RAM_ADDR_BITS(2), .NUM_OUTPUTS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .read_addr(read_addr2), .RAM_out(ram_out2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
    .m_axis_tlast(tlast2), .busy(busy2), .done(done2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef OUTPUT_STREAMER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   words_acc = 0;
  int   done_cnt  = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  // Scoreboard monitor: compare every accepted word, check holds during stalls.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_tvalid", {31'd0, tvalid}, 32'd1);
        check("hold_tdata", tdata, prev_data);
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %h expected none", tdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word_data", tdata, e.data);
          check("word_last", {31'd0, tlast}, {31'd0, e.last});
          words_acc++;
        end
      end
      if (done) done_cnt++;
    end
    prev_stall = !rst && tvalid && !tready;
    prev_data  = tdata;
  end

  typedef struct {
    logic [3:0][31:0] w;
    logic [15:0]      pat;
    int               pat_len;
    int               done_edge;
  } vec_t;

  vec_t vecs[4];

  task automatic push_frame(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      ram[i] = v.w[i];
      sb.push_back('{data: exp_word(v.w[i]), last: (i == 3)});
    end
  endtask

  // Stream one frame; pat bit j is tready during the j-th SEND cycle.
  task automatic run_frame(input vec_t v, input string tag);
    bit found;
    push_frame(v);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    tready = 1'b0;
    check({tag, "_fetch_tvalid"}, {31'd0, tvalid}, 32'd0);
    check({tag, "_fetch_busy"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    found = 1'b0;
    for (int j = 0; j < 40; j++) begin
      #1;
      if (j == 0) check({tag, "_first_valid"}, {31'd0, tvalid}, 32'd1);
      if (j > 0 && done) begin
        check({tag, "_done_edge"}, j + 1, v.done_edge);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
        found = 1'b1;
        break;
      end
      tready = (j < v.pat_len) ? v.pat[j] : 1'b1;
      @(posedge clk);
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s_done_timeout: got no done expected done pulse", tag);
    end
    tready = 1'b0;
    @(posedge clk);
    #1 check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{w: {32'hFFFF_FFD8, 32'd30, 32'hFFFF_FFEC, 32'd10},
                pat: 16'h0, pat_len: 0, done_edge: 5};
    vecs[1] = '{w: {32'hFFFF_FFD8, 32'd30, 32'hFFFF_FFEC, 32'd10},
                pat: 16'b1101001, pat_len: 7, done_edge: 8};
    vecs[2] = '{w: {32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1234_5678},
                pat: 16'b11110, pat_len: 5, done_edge: 6};
    vecs[3] = '{w: {32'd4, 32'd3, 32'd2, 32'd1},
                pat: 16'b1000111, pat_len: 7, done_edge: 8};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; tready = 1'b0; tready2 = 1'b1;
    for (int i = 0; i < 4; i++) ram[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_read_addr", {30'd0, read_addr}, 32'd0);
    check("rst_tlast", {31'd0, tlast}, 32'd0);
    rst = 1'b0;

    foreach (vecs[k]) run_frame(vecs[k], $sformatf("vec%0d", k));

    // Reset in the cycle after the second handshake.
    push_frame(vecs[0]);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    tready = 1'b0;
    check("pre_rst_words", words_acc % 4, 32'd2);
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_tvalid", {31'd0, tvalid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_tdata", tdata, 32'd0);
    check("midrst_read_addr", {30'd0, read_addr}, 32'd0);
    sb.delete();
    run_frame(vecs[0], "after_rst");

    // Start pulsed while busy must be ignored.
    words_acc = 0;
    done_cnt  = 0;
    push_frame(vecs[0]);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("busy_start_words", words_acc, 32'd4);
    check("busy_start_done", done_cnt, 32'd1);
    check("busy_start_sb", sb.size(), 32'd0);
    tready = 1'b0;

    // Single-word frame on the NUM_OUTPUTS=1 instance.
    @(posedge clk);
    #1 start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    check("one_fetch_tvalid", {31'd0, tvalid2}, 32'd0);
    check("one_fetch_busy", {31'd0, busy2}, 32'd1);
    @(posedge clk);
    #1;
    check("one_tvalid", {31'd0, tvalid2}, 32'd1);
    check("one_tlast", {31'd0, tlast2}, 32'd1);
    check("one_tdata", tdata2, exp_word(32'h1234_5678));
    @(posedge clk);
    #1;
    check("one_after_tvalid", {31'd0, tvalid2}, 32'd0);
    check("one_done", {31'd0, done2}, 32'd1);
    @(posedge clk);
    #1;
    check("one_done_clear", {31'd0, done2}, 32'd0);
    check("one_idle_busy", {31'd0, busy2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_streamer.md
OUTPUT_STREAMER -- requirements
Module: output_streamer

Interface
REQ-001 Parameter RAM_WIDTH, default 32, SHALL set the width of the output-RAM word and of the stream data.
REQ-002 Parameter RAM_ADDR_BITS, default 2, SHALL set the output-RAM address width.
REQ-003 Parameter NUM_OUTPUTS, default 4, SHALL set the words sent per frame; legal range 1..2**RAM_ADDR_BITS.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-006 Port start, input, 1 bit, SHALL be a one-cycle request to stream one frame.
REQ-007 Port read_addr, output, RAM_ADDR_BITS bits, SHALL be the output-RAM read address.
REQ-008 Port RAM_out, input, RAM_WIDTH bits signed, SHALL be the output-RAM asynchronous read data for read_addr.
REQ-009 Port m_axis_tdata, output, RAM_WIDTH bits, SHALL be the registered stream data.
REQ-010 Port m_axis_tvalid, output, 1 bit, SHALL be the registered stream valid.
REQ-011 Port m_axis_tready, input, 1 bit, SHALL be the downstream ready.
REQ-012 Port m_axis_tlast, output, 1 bit, SHALL mark the final word of a frame.
REQ-013 Port busy, output, 1 bit, SHALL be high in every state except IDLE.
REQ-014 Port done, output, 1 bit, SHALL pulse high for one cycle after the last word is accepted.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, SEND, DONE.
REQ-016 IDLE: on start=1, idx SHALL clear to 0 and the FSM SHALL enter FETCH; start outside IDLE SHALL be ignored.
REQ-017 FETCH: read_addr SHALL equal idx; tdata SHALL load RAM_out, tvalid SHALL set to 1, and the FSM SHALL enter SEND.
REQ-018 SEND: read_addr SHALL equal idx+1 truncated to RAM_ADDR_BITS; tdata and tvalid SHALL hold while tready=0.
REQ-019 SEND handshake (tvalid&tready) with idx<NUM_OUTPUTS-1: idx SHALL increment and tdata SHALL load RAM_out in the same edge, with tvalid kept at 1 (one word per cycle sustained).
REQ-020 SEND handshake with idx=NUM_OUTPUTS-1: tvalid SHALL clear and the FSM SHALL enter DONE.
REQ-021 m_axis_tlast SHALL equal tvalid && idx==NUM_OUTPUTS-1.
REQ-022 DONE: done SHALL be 1 for exactly that cycle, then the FSM SHALL return to IDLE.
REQ-023 Latency: the first word SHALL be valid 2 cycles after the cycle that samples start; a frame with tready held at 1 SHALL take NUM_OUTPUTS+3 cycles from start to IDLE.
REQ-024 NUM_OUTPUTS=1: FETCH SHALL present a word with tlast=1 immediately.
REQ-025 tdata SHALL be passed bit-exact; no sign extension or arithmetic.
REQ-026 RAM writes during a frame SHALL be visible only for words not yet loaded into tdata.

Reset
REQ-027 On rst=1, state SHALL be IDLE, idx=0, tdata=0, tvalid=0, done=0, and busy=0 at the next edge, including mid-frame; the partial frame SHALL be abandoned.
REQ-028 read_addr SHALL be 0 while in IDLE.
REQ-029 rst SHALL take priority over start and over handshakes.

Configuration
REQ-030 Macro OUTPUT_STREAMER_BYTESWAP_EN: when defined, the loaded tdata SHALL be RAM_out with byte order reversed. RAM_WIDTH must then be a multiple of 8.
REQ-031 When OUTPUT_STREAMER_BYTESWAP_EN is not defined, tdata SHALL equal RAM_out unchanged.

Structure
REQ-032 A shared package/header SHALL hold the FSM state encodings (2-bit) and the default RAM_WIDTH/RAM_ADDR_BITS constants used by both the output RAM and this block.
REQ-033 No sub-module is required; the index counter and FSM SHALL live in output_streamer.

Verification
REQ-034 RAM={10,-20,30,-40}, tready=1, start pulse -> tdata 10,-20,30,-40 on 4 consecutive cycles, tlast on -40 only, done 1 cycle later.
REQ-035 Same data, tready toggled 1,0,0,1,0,1,1 -> each word is held while tready=0, no word is lost or duplicated, and the order is unchanged.
REQ-036 rst asserted on the cycle after the second handshake -> next cycle tvalid=0, busy=0, and a new start streams from word 10.
REQ-037 start pulsed while busy -> ignored; exactly 4 words and 1 done are produced.
REQ-038 NUM_OUTPUTS=1, RAM[0]=0x12345678 -> a single word with tlast=1; with OUTPUT_STREAMER_BYTESWAP_EN the word is 0x78563412.
